// File: rtl/serial_subtract_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial subtraction sequencer.
interface serial_subtract_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtraction sequencer: one full-subtract cell (two half
// subtractors plus a borrow OR) is reused for every bit position, LSB first.
// The result registers only update when the last bit has been produced, so
// partial differences are never visible on the outputs.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtract_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] pr;
    logic             bq;
    logic [CW-1:0]    cnt;

    logic hs1_d;
    logic hs1_b;
    logic hs2_d;
    logic hs2_b;
    logic cell_d;
    logic cell_b;

    // Shared full-subtract cell built from two half subtractors and a borrow OR.
    always_comb begin
        hs1_d  = sa[0] ^ sb[0];
        hs1_b  = ~sa[0] & sb[0];
        hs2_d  = hs1_d ^ bq;
        hs2_b  = ~hs1_d & bq;
        cell_d = hs2_d;
        cell_b = hs1_b | hs2_b;
    end

    // Sequencer: accept operands, shift one bit per clock, publish on the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            sa             <= '0;
            sb             <= '0;
            pr             <= '0;
            bq             <= 1'b0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sa       <= bus.a;
                        sb       <= bus.b;
                        bq       <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    pr  <= {cell_d, pr[WIDTH-1:1]};
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    bq  <= cell_b;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.diff       <= {cell_d, pr[WIDTH-1:1]};
                        bus.borrow_out <= cell_b;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_subtract_ctrl.md
# serial_subtract_ctrl

Bit-serial subtraction sequencer. It computes an N-bit unsigned difference by driving a single 1-bit full-subtract cell one bit per clock, LSB first. The cell is built from two half-subtractor cells plus a borrow OR. The block sits beside the team's 1-bit arithmetic cells and time-shares one cell across all bit positions, trading latency for area. A start/busy/done handshake fronts it for the surrounding control logic.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend; sampled on the accepting edge only
- b  in  WIDTH  subtrahend; sampled on the accepting edge only
- busy  out  1  high while bits are being processed (RUN)
- done  out  1  one-cycle pulse; result valid
- diff  out  WIDTH  (a - b) mod 2^WIDTH, registered
- borrow_out  out  1  1 iff a < b (unsigned), registered

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1, busy=0.
- IDLE, start=1 at an edge:
  - load a into shift register sa and b into shift register sb;
  - clear borrow flop bq and bit counter cnt;
  - go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, every edge:
  - d = sa[0] ^ sb[0] ^ bq;
  - bq <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bq);
  - shift d into the MSB of partial register pr (right shift);
  - shift sa and sb right by one;
  - cnt <= cnt + 1.
- RUN, edge where cnt == WIDTH-1:
  - diff <= final pr value, including this edge's d;
  - borrow_out <= final bq;
  - go to DONE.
- DONE, next edge: go to IDLE unconditionally.
- diff and borrow_out change only on the RUN→DONE edge. They hold the previous result through all of RUN and IDLE until the next completion. Partial sums are never visible.
- start while in RUN or DONE is ignored. It is not queued and has no effect on the current operation.
- a and b may change freely after the accepting edge.
- cnt width is clog2(WIDTH). No wrap is possible, because the exit is taken at WIDTH-1.

## Timing
- Reset, rst_n=0 at an edge:
  - state=IDLE, busy=0, done=0, diff=0, borrow_out=0;
  - sa, sb, pr, bq and cnt are all cleared.
- Reset overrides start and any RUN/DONE activity.
- Reset mid-RUN aborts the operation: no done pulse and no result update. Outputs show the reset values.
- Let E0 be the edge that accepts start:
  - busy is high in the cycles after E0 through E(WIDTH), i.e. exactly WIDTH cycles;
  - done is high for exactly one cycle, following E(WIDTH);
  - the result is valid from E(WIDTH) onward;
  - state is back in IDLE after E(WIDTH+1).
- Earliest next accept is E(WIDTH+2), with start high during the IDLE cycle. Back-to-back throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulsed for 1 cycle:
  - busy high for 8 cycles, then done for 1 cycle;
  - diff=0x1E, borrow_out=0.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1. Also a=0x00, b=0xFF → diff=0x01, borrow_out=1.
- a=0x77, b=0x77 → diff=0x00, borrow_out=0.
- Check that diff/borrow_out hold the prior result (0x1E/0) during the whole RUN of the next operation.
- start held high continuously with a/b changed during RUN:
  - only the operands at each accepting edge are used;
  - accepts are spaced exactly 10 cycles apart.
- Abort and recovery:
  - complete an operation, start a=0xF0, b=0x0F, then drive rst_n=0 at the 4th RUN edge;
  - no done pulse; diff=0, borrow_out=0, busy=0 the cycle after;
  - a fresh start then completes normally with diff=0xE1, borrow_out=0.
